uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport drives requests and the transmitter busy flag.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   gnt;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic               err;

  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, gnt, tx_data, tx_start, err
  );

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, gnt, tx_data, tx_start, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, with packet lock across multi-byte transfers.
// Optional abort on a stuck transmitter is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [PTR_W-1:0] idx_t;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, NEXT} state_t;

  generate
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("uart_tx_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT < 1 || TO_W > 31 || TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT must fit in TO_W bits");
    end
  endgenerate

  state_t            state, state_n;
  idx_t              owner, rr_ptr, pick_idx, load_idx;
  logic              pick_valid, lock;
  logic              grant, relock, load, finish, release_gnt;
  logic [N_REQ-1:0]  gnt_q, ack_q;
  logic [7:0]        tx_data_q, load_byte;

  function automatic logic [N_REQ-1:0] onehot(idx_t i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // First requesting index strictly after rr_ptr, wrapping; the loop runs
  // from the farthest offset down so the nearest one is written last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.req[idx_t'((int'(rr_ptr) + i) % N_REQ)]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_t'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            timed_out, abort;
  assign timed_out = (state == WAIT_BUSY || state == WAIT_DONE) && (to_cnt == TO_W'(TIMEOUT));
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n     = state;
    grant       = 1'b0;
    relock      = 1'b0;
    finish      = 1'b0;
    release_gnt = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    abort       = 1'b0;
`endif
    case (state)
      IDLE:      if (pick_valid) begin
                   grant   = 1'b1;
                   state_n = START;
                 end
      START:     state_n = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) state_n = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) begin
                   finish  = 1'b1;
                   state_n = NEXT;
                 end
      NEXT:      if (lock && bus.req[owner]) begin
                   relock  = 1'b1;
                   state_n = START;
                 end else begin
                   release_gnt = 1'b1;
                   state_n     = IDLE;
                 end
      default:   state_n = IDLE;
    endcase
`ifdef UART_ARB_TIMEOUT_EN
    if (timed_out) begin
      finish  = 1'b0;
      abort   = 1'b1;
      state_n = IDLE;
    end
`endif
  end

  // The byte is captured on entry to START so tx_data is valid alongside tx_start.
  assign load      = grant | relock;
  assign load_idx  = (state == IDLE) ? pick_idx : owner;
  assign load_byte = bus.req_data[{load_idx, 3'b000} +: 8];

  always_ff @(posedge sysclk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= idx_t'(N_REQ - 1);
      lock      <= 1'b0;
      gnt_q     <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state <= state_n;
      ack_q <= '0;
      if (load) begin
        owner     <= load_idx;
        gnt_q     <= onehot(load_idx);
        tx_data_q <= load_byte;
      end
      if (state == START) lock <= ~bus.req_last[owner];
      if (finish) begin
        ack_q  <= onehot(owner);
        rr_ptr <= owner;
      end
      if (release_gnt) begin
        gnt_q <= '0;
        lock  <= 1'b0;
      end
`ifdef UART_ARB_TIMEOUT_EN
      if (state == START) to_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      if (abort) begin
        gnt_q  <= '0;
        lock   <= 1'b0;
        rr_ptr <= owner;
      end
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = (state == START);
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.err      = timed_out;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic compared against a packet-level round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 20;

  typedef struct { logic [7:0] data; logic last; } byte_t;
  typedef struct { int who; logic [7:0] data; } ev_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .TO_W(16)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  byte_t rq [N][$];
  ev_t   tx_log[$], exp_log[$];
  int    ack_log[$];
  int    checks = 0, failures = 0, cyc = 0;
  int    err_cnt = 0, onehot_bad = 0, multi_ack = 0, fall_cyc = 0, ack_cyc = 0;
  bit    model_en = 1'b0, rand_tx = 1'b0;
  int    busy_len = 10;

  always @(posedge sysclk) cyc++;

  function automatic int idx_of(logic [N-1:0] v);
    idx_of = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i] === 1'b1) idx_of = i;
  endfunction

  // Transmitter model: busy rises 1..3 cycles after a start pulse and holds for a set time.
  initial begin
    int  delay_left, busy_left;
    bit  pending;
    bus.tx_busy = 1'b0;
    pending = 1'b0; busy_left = 0; delay_left = 0;
    forever begin
      @(posedge sysclk); #1;
      if (reset || !model_en) begin
        bus.tx_busy = 1'b0; pending = 1'b0; busy_left = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          bus.tx_busy = 1'b0;
          fall_cyc = cyc;
        end
      end else if (pending) begin
        if (delay_left == 0) begin
          bus.tx_busy = 1'b1;
          busy_left   = rand_tx ? int'($urandom_range(1, 6)) : busy_len;
          pending     = 1'b0;
        end else delay_left--;
      end
      if (bus.tx_start === 1'b1) begin
        tx_log.push_back('{who: idx_of(bus.gnt), data: bus.tx_data});
        if (model_en && !reset) begin
          pending    = 1'b1;
          delay_left = rand_tx ? int'($urandom_range(0, 2)) : 0;
        end
      end
      if (bus.err === 1'b1) err_cnt++;
      if (!$onehot0(bus.gnt)) onehot_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        bus.req[i]           = 1'b1;
        bus.req_data[8*i +: 8] = rq[i][0].data;
        bus.req_last[i]      = rq[i][0].last;
      end else begin
        bus.req[i]           = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]      = 1'b0;
      end
    end
  endtask

  // One clock: requesters retire the acked byte and present their next one in the ack cycle.
  task automatic step();
    @(posedge sysclk); #1;
    if (bus.ack !== '0) begin
      if (!$onehot(bus.ack)) multi_ack++;
      ack_log.push_back(idx_of(bus.ack));
      ack_cyc = cyc;
      for (int i = 0; i < N; i++)
        if (bus.ack[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_en = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive_reqs();
    repeat (2) @(posedge sysclk);
    #1;
    reset = 1'b0;
    tx_log.delete(); ack_log.delete(); exp_log.delete();
    err_cnt = 0;
  endtask

  task automatic run_until_idle(string tag, int max_cyc);
    int n = 0, quiet = 0;
    bit empty;
    while (n < max_cyc && quiet < 4) begin
      step();
      n++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) empty = 1'b0;
      if (empty && bus.gnt === '0 && bus.tx_busy === 1'b0) quiet++;
      else quiet = 0;
    end
    check({tag, "_finished_in_budget"}, 32'(n < max_cyc), 32'd1);
  endtask

  // Packet-level reference: pick the first non-empty requester after the last
  // owner, send its bytes until last=1 or it runs dry, then move on.
  function automatic void predict();
    byte_t q [N][$];
    byte_t b;
    int    rr = N - 1;
    q = rq;
    forever begin
      int o = -1;
      for (int k = 1; k <= N; k++)
        if (o < 0 && q[(rr + k) % N].size() > 0) o = (rr + k) % N;
      if (o < 0) break;
      do begin
        b = q[o].pop_front();
        exp_log.push_back('{who: o, data: b.data});
      end while (!b.last && q[o].size() > 0);
      rr = o;
    end
  endfunction

  task automatic compare_logs(string tag);
    check({tag, "_tx_count"}, tx_log.size(), exp_log.size());
    check({tag, "_ack_count"}, ack_log.size(), exp_log.size());
    for (int k = 0; k < exp_log.size(); k++) begin
      if (k < tx_log.size()) begin
        check($sformatf("%s_tx%0d_who", tag, k), tx_log[k].who, exp_log[k].who);
        check($sformatf("%s_tx%0d_data", tag, k), 32'(tx_log[k].data), 32'(exp_log[k].data));
      end
      if (k < ack_log.size())
        check($sformatf("%s_ack%0d_who", tag, k), ack_log[k], exp_log[k].who);
    end
  endtask

  initial begin
    int n;
    int    exp_who [];
    byte_t pkt;

    // Reset state
    drive_reqs();
    repeat (2) @(posedge sysclk);
    #1;
    check("reset_gnt", 32'(bus.gnt), 32'd0);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("reset_tx_start", 32'(bus.tx_start), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);

    // Single byte from requester 2
    do_reset();
    model_en = 1'b1; rand_tx = 1'b0; busy_len = 10;
    rq[2].push_back('{data: 8'h5A, last: 1'b1});
    drive_reqs();
    step();
    check("single_gnt", 32'(bus.gnt), 32'b0100);
    check("single_tx_start", 32'(bus.tx_start), 32'd1);
    check("single_tx_data", 32'(bus.tx_data), 32'h5A);
    step();
    check("single_start_one_cycle", 32'(bus.tx_start), 32'd0);
    n = 0;
    while (ack_log.size() == 0 && n < 40) begin step(); n++; end
    check("single_ack_seen", ack_log.size(), 1);
    check("single_ack_vec", 32'(bus.ack), 32'b0100);
    check("single_ack_after_fall", ack_cyc - fall_cyc, 1);
    step();
    check("single_gnt_clear", 32'(bus.gnt), 32'd0);
    check("single_ack_one_cycle", 32'(bus.ack), 32'd0);

    // Round robin with all four requesting
    do_reset();
    model_en = 1'b1; busy_len = 3;
    rq[0].push_back('{data: 8'h01, last: 1'b1});
    rq[0].push_back('{data: 8'h05, last: 1'b1});
    rq[1].push_back('{data: 8'h02, last: 1'b1});
    rq[2].push_back('{data: 8'h03, last: 1'b1});
    rq[3].push_back('{data: 8'h04, last: 1'b1});
    drive_reqs();
    run_until_idle("rr", 400);
    exp_who = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) exp_log.push_back('{who: exp_who[k], data: 8'(k + 1)});
    compare_logs("rr");

    // Locked 3-byte packet on requester 1 while requester 3 waits
    do_reset();
    model_en = 1'b1; busy_len = 4;
    rq[1].push_back('{data: 8'h11, last: 1'b0});
    rq[1].push_back('{data: 8'h22, last: 1'b0});
    rq[1].push_back('{data: 8'h33, last: 1'b1});
    rq[3].push_back('{data: 8'h44, last: 1'b1});
    drive_reqs();
    run_until_idle("lock", 400);
    exp_log.push_back('{who: 1, data: 8'h11});
    exp_log.push_back('{who: 1, data: 8'h22});
    exp_log.push_back('{who: 1, data: 8'h33});
    exp_log.push_back('{who: 3, data: 8'h44});
    compare_logs("lock");

    // Abandoned packet: requester 0 sends last=0 then drops its request
    do_reset();
    model_en = 1'b1; busy_len = 2;
    rq[0].push_back('{data: 8'hA0, last: 1'b0});
    rq[2].push_back('{data: 8'hB2, last: 1'b1});
    drive_reqs();
    run_until_idle("abandon", 300);
    exp_log.push_back('{who: 0, data: 8'hA0});
    exp_log.push_back('{who: 2, data: 8'hB2});
    compare_logs("abandon");
    check("abandon_no_err", err_cnt, 0);
    check("abandon_gnt_clear", 32'(bus.gnt), 32'd0);

    // Transmitter never goes busy
    do_reset();
    model_en = 1'b0;
    rq[1].push_back('{data: 8'hC1, last: 1'b1});
    drive_reqs();
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.err === 1'b1) begin
        rq[1].delete();
        drive_reqs();
      end
    end
    check("stuck_no_ack", ack_log.size(), 0);
    check("stuck_one_start", tx_log.size(), 1);
`ifdef UART_ARB_TIMEOUT_EN
    check("timeout_err_once", err_cnt, 1);
    check("timeout_gnt_clear", 32'(bus.gnt), 32'd0);
`else
    check("stuck_no_err", err_cnt, 0);
    check("stuck_gnt_held", 32'(bus.gnt), 32'b0010);
`endif

    // Reset while waiting for the transmitter to finish
    do_reset();
    model_en = 1'b1; busy_len = 20;
    rq[3].push_back('{data: 8'hD3, last: 1'b1});
    drive_reqs();
    n = 0;
    while (bus.tx_busy !== 1'b1 && n < 20) begin step(); n++; end
    repeat (3) step();
    check("mid_owner_before_reset", 32'(bus.gnt), 32'b1000);
    reset = 1'b1;
    model_en = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive_reqs();
    @(posedge sysclk); #1;
    check("mid_reset_gnt", 32'(bus.gnt), 32'd0);
    check("mid_reset_ack", 32'(bus.ack), 32'd0);
    check("mid_reset_tx_start", 32'(bus.tx_start), 32'd0);
    check("mid_reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("mid_reset_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    repeat (30) step();
    check("mid_reset_no_ack", ack_log.size(), 0);
    rq[0].push_back('{data: 8'hE0, last: 1'b1});
    drive_reqs();
    model_en = 1'b1; busy_len = 2;
    step();
    check("mid_reset_regrant_0", 32'(bus.gnt), 32'b0001);
    run_until_idle("mid_reset_drain", 100);

    // Randomized traffic against the packet-level model
    for (int round = 0; round < 4; round++) begin
      do_reset();
      model_en = 1'b1; rand_tx = 1'b1;
      for (int i = 0; i < N; i++) begin
        int npkt = $urandom_range(0, 3);
        for (int p = 0; p < npkt; p++) begin
          int len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            pkt.data = 8'($urandom);
            pkt.last = (b == len - 1);
            if (p == npkt - 1 && b == len - 1 && $urandom_range(0, 3) == 0) pkt.last = 1'b0;
            rq[i].push_back(pkt);
          end
        end
      end
      predict();
      drive_reqs();
      run_until_idle($sformatf("rand%0d", round), 3000);
      compare_logs($sformatf("rand%0d", round));
      check($sformatf("rand%0d_no_err", round), err_cnt, 0);
    end

    check("gnt_never_multi_hot", onehot_bad, 0);
    check("ack_never_multi_hot", multi_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
